// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor
// Adapts one-line-per-request cache traffic to a BUS_W-wide beat interface:
// fills gather LINE_W/BUS_W beats into ca_rdata, writebacks serialise ca_wdata.
// Optional build macro: CA_CWF_EN (critical word first on fills).
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   ca_read/ca_write   line fill / writeback request (sampled in IDLE only)
//   ca_addr, ca_wdata  line byte address and writeback data
//   ca_rdata, ca_resp  assembled fill line and one-cycle completion pulse
//   pm_read/pm_write   beat request, held high for a whole burst
//   pm_addr, pm_wdata  beat byte address and write data
//   pm_rdata, pm_resp  beat read data and beat accept/valid
module cacheline_burst_adaptor #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned BUS_W  = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ca_read,
    input  logic              ca_write,
    input  logic [ADDR_W-1:0] ca_addr,
    input  logic [LINE_W-1:0] ca_wdata,
    output logic [LINE_W-1:0] ca_rdata,
    output logic              ca_resp,
    output logic              pm_read,
    output logic              pm_write,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [BUS_W-1:0]  pm_wdata,
    input  logic [BUS_W-1:0]  pm_rdata,
    input  logic              pm_resp
);

    localparam int unsigned BEATS  = LINE_W / BUS_W;
    localparam int unsigned BB     = BUS_W / 8;
    localparam int unsigned LB     = LINE_W / 8;
    localparam int unsigned CNT_W  = $clog2(BEATS);
    localparam int unsigned BOFF_W = $clog2(BB);
    localparam int unsigned LOFF_W = $clog2(LB);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   start_q, start_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [LINE_W-1:0]  shreg_q, shreg_d;
    logic [LINE_W-1:0]  ca_rdata_q, ca_rdata_d;
    logic               ca_resp_q, ca_resp_d;
    logic               pm_read_q, pm_read_d;
    logic               pm_write_q, pm_write_d;
    logic [ADDR_W-1:0]  pm_addr_q, pm_addr_d;
    logic [BUS_W-1:0]   pm_wdata_q, pm_wdata_d;

    logic [ADDR_W-1:0]  line_base;
    logic [CNT_W-1:0]   req_start;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   idx_nxt;
    logic               last_beat;

    // Line-aligned base address; beat offsets are ORed in so they never carry
    // across the line boundary.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] b,
                                                    input logic [CNT_W-1:0]  i);
        beat_addr = b | (ADDR_W'(i) << BOFF_W);
    endfunction

    assign line_base = ca_addr & ~ADDR_W'(LB - 1);

`ifdef CA_CWF_EN
    assign req_start = ca_addr[LOFF_W-1:BOFF_W];
`else
    assign req_start = '0;
`endif

    // Slot index wraps naturally because BEATS is a power of two.
    assign cnt_nxt   = cnt_q + CNT_W'(1);
    assign idx       = start_q + cnt_q;
    assign idx_nxt   = start_q + cnt_nxt;
    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        start_d    = start_q;
        base_d     = base_q;
        shreg_d    = shreg_q;
        ca_rdata_d = ca_rdata_q;
        ca_resp_d  = 1'b0;
        pm_read_d  = pm_read_q;
        pm_write_d = pm_write_q;
        pm_addr_d  = pm_addr_q;
        pm_wdata_d = pm_wdata_q;

        case (state_q)
            IDLE: begin
                if (ca_write || ca_read) begin
                    base_d  = line_base;
                    shreg_d = ca_wdata;
                    cnt_d   = '0;
                    if (ca_write) begin
                        state_d    = WR;
                        start_d    = '0;
                        pm_write_d = 1'b1;
                        pm_addr_d  = line_base;
                        pm_wdata_d = ca_wdata[BUS_W-1:0];
                    end else begin
                        state_d   = RD;
                        start_d   = req_start;
                        pm_read_d = 1'b1;
                        pm_addr_d = beat_addr(line_base, req_start);
                    end
                end
            end
            RD: begin
                if (pm_resp) begin
                    ca_rdata_d[int'(idx) * BUS_W +: BUS_W] = pm_rdata;
                    cnt_d     = cnt_nxt;
                    pm_addr_d = beat_addr(base_q, idx_nxt);
                    if (last_beat) begin
                        pm_read_d = 1'b0;
                        state_d   = DONE;
                    end
                end
            end
            WR: begin
                if (pm_resp) begin
                    shreg_d    = shreg_q >> BUS_W;
                    pm_wdata_d = shreg_q[2*BUS_W-1:BUS_W];
                    cnt_d      = cnt_nxt;
                    pm_addr_d  = beat_addr(base_q, idx_nxt);
                    if (last_beat) begin
                        pm_write_d = 1'b0;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                ca_resp_d = 1'b1;
                cnt_d     = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            start_q    <= '0;
            base_q     <= '0;
            shreg_q    <= '0;
            ca_rdata_q <= '0;
            ca_resp_q  <= 1'b0;
            pm_read_q  <= 1'b0;
            pm_write_q <= 1'b0;
            pm_addr_q  <= '0;
            pm_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            base_q     <= base_d;
            shreg_q    <= shreg_d;
            ca_rdata_q <= ca_rdata_d;
            ca_resp_q  <= ca_resp_d;
            pm_read_q  <= pm_read_d;
            pm_write_q <= pm_write_d;
            pm_addr_q  <= pm_addr_d;
            pm_wdata_q <= pm_wdata_d;
        end
    end

    assign ca_rdata = ca_rdata_q;
    assign ca_resp  = ca_resp_q;
    assign pm_read  = pm_read_q;
    assign pm_write = pm_write_q;
    assign pm_addr  = pm_addr_q;
    assign pm_wdata = pm_wdata_q;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Bench for cacheline_burst_adaptor: a 256/32 instance and a 128/64 instance.
// Stimulus pushes expected beats and completions into queues; a monitor
// process on the falling edge pops and compares them.
module tb_cacheline_burst_adaptor;

    logic clk = 1'b0;
    logic rst;
    logic pm_resp;
    logic [31:0] salt;

    // main instance: LINE_W=256, BUS_W=32
    logic         m_ca_read, m_ca_write;
    logic [31:0]  m_ca_addr;
    logic [255:0] m_ca_wdata, m_ca_rdata;
    logic         m_ca_resp, m_pm_read, m_pm_write;
    logic [31:0]  m_pm_addr, m_pm_wdata, m_pm_rdata;

    // small instance: LINE_W=128, BUS_W=64
    logic         s_ca_read, s_ca_write;
    logic [31:0]  s_ca_addr;
    logic [127:0] s_ca_wdata, s_ca_rdata;
    logic         s_ca_resp, s_pm_read, s_pm_write;
    logic [31:0]  s_pm_addr;
    logic [63:0]  s_pm_wdata, s_pm_rdata;

    always #5 clk = ~clk;

    cacheline_burst_adaptor #(.LINE_W(256), .BUS_W(32), .ADDR_W(32)) u_main (
        .clk(clk), .rst(rst),
        .ca_read(m_ca_read), .ca_write(m_ca_write), .ca_addr(m_ca_addr),
        .ca_wdata(m_ca_wdata), .ca_rdata(m_ca_rdata), .ca_resp(m_ca_resp),
        .pm_read(m_pm_read), .pm_write(m_pm_write), .pm_addr(m_pm_addr),
        .pm_wdata(m_pm_wdata), .pm_rdata(m_pm_rdata), .pm_resp(pm_resp)
    );

    cacheline_burst_adaptor #(.LINE_W(128), .BUS_W(64), .ADDR_W(32)) u_small (
        .clk(clk), .rst(rst),
        .ca_read(s_ca_read), .ca_write(s_ca_write), .ca_addr(s_ca_addr),
        .ca_wdata(s_ca_wdata), .ca_rdata(s_ca_rdata), .ca_resp(s_ca_resp),
        .pm_read(s_pm_read), .pm_write(s_pm_write), .pm_addr(s_pm_addr),
        .pm_wdata(s_pm_wdata), .pm_rdata(s_pm_rdata), .pm_resp(pm_resp)
    );

    function automatic logic [31:0] m_word(input int i, input logic [31:0] sl);
        return (32'h1111_1111 * 32'(i + 1)) ^ sl;
    endfunction

    function automatic logic [63:0] s_word(input int i, input logic [31:0] sl);
        return {32'hA5A5_0000 | 32'(i), 32'h5A5A_0000 | 32'(i)} ^ {sl, sl};
    endfunction

    // Memory model: beat data depends on which beat of the line is addressed.
    always_comb begin
        m_pm_rdata = m_word(int'(m_pm_addr[4:2]), salt);
        s_pm_rdata = s_word(int'(s_pm_addr[3]), salt);
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [63:0] wdata;
    } beat_t;

    typedef struct {
        logic [255:0] line;
        int           cyc;
        int           active;
    } resp_t;

    beat_t beat_q[$];
    resp_t resp_q[$];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit sel     = 1'b0;
    logic [255:0] m_line = '0;
    logic [127:0] s_line = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beat addresses of a fill, in issue order.
    task automatic push_fill(input bit dut, input logic [31:0] addr, input int nb_push);
        int nb, bb, s, idx;
        logic [31:0] base;
        beat_t e;
        nb   = dut ? 2 : 8;
        bb   = dut ? 8 : 4;
        base = addr & ~32'(nb * bb - 1);
        s    = 0;
`ifdef CA_CWF_EN
        s = int'(addr - base) / bb;
`endif
        for (int k = 0; k < nb_push; k++) begin
            idx     = (s + k) % nb;
            e.wr    = 1'b0;
            e.addr  = base + 32'(idx * bb);
            e.wdata = '0;
            beat_q.push_back(e);
        end
    endtask

    task automatic fill_line(input bit dut);
        if (dut) for (int i = 0; i < 2; i++) s_line[i*64 +: 64] = s_word(i, salt);
        else     for (int i = 0; i < 8; i++) m_line[i*32 +: 32] = m_word(i, salt);
    endtask

    task automatic push_wb(input bit dut, input logic [31:0] addr, input logic [255:0] wd);
        int nb, bb;
        logic [31:0] base;
        beat_t e;
        nb   = dut ? 2 : 8;
        bb   = dut ? 8 : 4;
        base = addr & ~32'(nb * bb - 1);
        for (int i = 0; i < nb; i++) begin
            e.wr    = 1'b1;
            e.addr  = base + 32'(i * bb);
            e.wdata = dut ? wd[i*64 +: 64] : 64'(wd[i*32 +: 32]);
            beat_q.push_back(e);
        end
    endtask

    task automatic push_resp(input bit dut, input int at_cyc, input int active);
        resp_t r;
        r.line   = dut ? 256'(s_line) : m_line;
        r.cyc    = at_cyc;
        r.active = active;
        resp_q.push_back(r);
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while ((resp_q.size() != 0 || beat_q.size() != 0) && i < 60) begin
            tick();
            i++;
        end
        chk({name, "_drain"}, 256'(resp_q.size() + beat_q.size()), '0);
    endtask

    // Monitor: checks every cycle with a request on the memory side and every completion.
    initial begin
        int active;
        logic mrd, mwr, mresp;
        logic [31:0] maddr;
        logic [63:0] mwd;
        logic [255:0] mline;
        beat_t e;
        resp_t r;
        active = 0;
        forever begin
            @(negedge clk);
            mrd   = sel ? s_pm_read  : m_pm_read;
            mwr   = sel ? s_pm_write : m_pm_write;
            maddr = sel ? s_pm_addr  : m_pm_addr;
            mwd   = sel ? s_pm_wdata : 64'(m_pm_wdata);
            mresp = sel ? s_ca_resp  : m_ca_resp;
            mline = sel ? 256'(s_ca_rdata) : m_ca_rdata;
            if (rst) begin
                active = 0;
            end else begin
                if (mrd || mwr) begin
                    active++;
                    if (beat_q.size() == 0) begin
                        chk("unexpected_beat", 256'(maddr), '1);
                    end else begin
                        e = beat_q[0];
                        chk("pm_dir", {mrd, mwr}, {~e.wr, e.wr});
                        chk("pm_addr", 256'(maddr), 256'(e.addr));
                        if (e.wr) chk("pm_wdata", 256'(mwd), 256'(e.wdata));
                        if (pm_resp) void'(beat_q.pop_front());
                    end
                end
                if (mresp) begin
                    if (resp_q.size() == 0) begin
                        chk("unexpected_ca_resp", 256'(cyc), '1);
                    end else begin
                        r = resp_q.pop_front();
                        chk("ca_rdata", mline, r.line);
                        chk("resp_cycle", 256'(cyc), 256'(r.cyc));
                        chk("burst_active_cycles", 256'(active), 256'(r.active));
                        active = 0;
                    end
                end
            end
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        logic [255:0] wd;
        rst = 1'b1;
        pm_resp = 1'b1;
        salt = '0;
        m_ca_read = 0; m_ca_write = 0; m_ca_addr = '0; m_ca_wdata = '0;
        s_ca_read = 0; s_ca_write = 0; s_ca_addr = '0; s_ca_wdata = '0;
        #3;
        chk("reset_main", {m_ca_rdata, m_pm_addr, m_pm_wdata, m_ca_resp, m_pm_read, m_pm_write}, '0);
        chk("reset_small", {s_ca_rdata, s_pm_addr, s_pm_wdata, s_ca_resp, s_pm_read, s_pm_write}, '0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Fill at 0x1234, pm_resp every cycle.
        salt = '0;
        m_ca_read = 1; m_ca_addr = 32'h0000_1234;
        r0 = cyc;
        push_fill(0, 32'h0000_1234, 8);
        fill_line(0);
        push_resp(0, r0 + 10, 8);
        tick();
        m_ca_read = 0;
        drain("fill_1234");
        chk("fill_word0", 256'(m_ca_rdata[31:0]), 256'(32'h1111_1111));
        chk("fill_word7", 256'(m_ca_rdata[255:224]), 256'(32'h8888_8888));

        // Writeback at 0x40 with 3-cycle stalls before beats 2 and 5.
        for (int i = 0; i < 8; i++) wd[i*32 +: 32] = 32'(i);
        m_ca_write = 1; m_ca_addr = 32'h0000_0040; m_ca_wdata = wd;
        r0 = cyc;
        push_wb(0, 32'h0000_0040, wd);
        push_resp(0, r0 + 16, 14);
        tick();
        m_ca_write = 0;
        for (int c = 1; c <= 14; c++) begin
            pm_resp = !(c inside {3, 4, 5, 9, 10, 11});
            tick();
        end
        pm_resp = 1'b1;
        drain("wb_stall");

        // Read and write together: writeback first, fill right after its ca_resp.
        for (int i = 0; i < 8; i++) wd[i*32 +: 32] = 32'hC0DE_0000 | 32'(i);
        salt = 32'h0F0F_0000;
        m_ca_read = 1; m_ca_write = 1; m_ca_addr = 32'h0000_0080; m_ca_wdata = wd;
        r0 = cyc;
        push_wb(0, 32'h0000_0080, wd);
        push_resp(0, r0 + 10, 8);
        push_fill(0, 32'h0000_0080, 8);
        fill_line(0);
        push_resp(0, r0 + 20, 8);
        tick();
        m_ca_write = 0;
        repeat (10) tick();
        m_ca_read = 0;
        drain("rd_wr_priority");

        // Reset after four beats of a fill.
        salt = 32'h3333_0000;
        m_ca_read = 1; m_ca_addr = 32'h0000_3000;
        push_fill(0, 32'h0000_3000, 4);
        tick();
        m_ca_read = 0;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        chk("midburst_reset_main",
            {m_ca_rdata, m_pm_addr, m_pm_wdata, m_ca_resp, m_pm_read, m_pm_write}, '0);
        chk("midburst_reset_beats_left", 256'(beat_q.size()), '0);
        m_line = '0;
        tick();
        rst = 1'b0;
        tick(); tick();
        salt = 32'h4444_0000;
        m_ca_read = 1; m_ca_addr = 32'h0000_3010;
        r0 = cyc;
        push_fill(0, 32'h0000_3010, 8);
        fill_line(0);
        push_resp(0, r0 + 10, 8);
        tick();
        m_ca_read = 0;
        drain("fill_after_reset");

        // 128/64 instance: fill with ignored low address bits, then writeback.
        sel = 1'b1;
        salt = 32'h0000_00F0;
        s_ca_read = 1; s_ca_addr = 32'h0000_010C;
        r0 = cyc;
        push_fill(1, 32'h0000_010C, 2);
        fill_line(1);
        push_resp(1, r0 + 4, 2);
        tick();
        s_ca_read = 0;
        drain("small_fill");
        wd = '0;
        wd[127:0] = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;
        s_ca_write = 1; s_ca_addr = 32'h0000_010F; s_ca_wdata = wd[127:0];
        r0 = cyc;
        push_wb(1, 32'h0000_010F, wd);
        push_resp(1, r0 + 4, 2);
        tick();
        s_ca_write = 0;
        drain("small_wb");

        repeat (3) tick();
        chk("queues_empty", 256'(beat_q.size() + resp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
